// File: rtl/addsub_pkg.sv
// Shared constants for the pipelined add/subtract unit.
// Optional saturation is enabled with the ADDSUB_SAT_EN macro.
package addsub_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_ADC = 2'b10;
    localparam logic [1:0] OP_SBC = 2'b11;

    localparam int FLAG_Z = 3;
    localparam int FLAG_N = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    function automatic logic op_inverts_b(input logic [1:0] op);
        return op[0];
    endfunction

    function automatic logic op_saturates(input logic [1:0] op);
        return !op[1];
    endfunction

endpackage

// File: rtl/addsub_if.sv
// Operand/result valid-ready bundle for pipelined_addsub.
// Master drives operands and out_ready; slave is the adder.
interface addsub_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [1:0]       in_op;
    logic             in_cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic [3:0]       out_flags;

    modport master (
        output in_valid, in_a, in_b, in_op, in_cin, out_ready,
        input  in_ready, out_valid, out_sum, out_flags
    );

    modport slave (
        input  in_valid, in_a, in_b, in_op, in_cin, out_ready,
        output in_ready, out_valid, out_sum, out_flags
    );

endinterface

// File: rtl/addsub_slice.sv
// CHUNK-bit combinational adder slice with carry in/out.
// One instance per pipeline stage of pipelined_addsub.
module addsub_slice #(
    parameter int W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout
);
    logic [W:0] full;

    assign full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    assign {cout, sum} = full;

endmodule

// File: rtl/pipelined_addsub.sv
// Carry-chain-pipelined ADD/SUB/ADC/SBC with Z/N/C/V flags.
// Define ADDSUB_SAT_EN to saturate ADD/SUB on signed overflow.
module pipelined_addsub #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 4
) (
    input  logic     clk,
    input  logic     rst_n,
    addsub_if.slave  bus
);
    import addsub_pkg::*;

    localparam int NSTAGE = WIDTH / CHUNK;

    typedef struct packed {
        logic             vld;
        logic             cy;
`ifdef ADDSUB_SAT_EN
        logic             sat;
`endif
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] s;
    } beat_t;

    logic             adv;
    beat_t            head;
    beat_t            fin;
    beat_t            sin  [NSTAGE];
    beat_t            sout [NSTAGE];
    logic [WIDTH-1:0] res;
    logic             ovf;
    logic [3:0]       flags;
    logic             out_valid_q;
    logic [WIDTH-1:0] out_sum_q;
    logic [3:0]       out_flags_q;

    // Whole pipe moves in lockstep; bubbles are kept.
    assign adv          = !out_valid_q || bus.out_ready;
    assign bus.in_ready = adv;

    always_comb begin
        head     = '0;
        head.vld = bus.in_valid;
        head.a   = bus.in_a;
        head.b   = op_inverts_b(bus.in_op) ? ~bus.in_b : bus.in_b;
        unique case (bus.in_op)
            OP_ADD:  head.cy = 1'b0;
            OP_SUB:  head.cy = 1'b1;
            default: head.cy = bus.in_cin;
        endcase
`ifdef ADDSUB_SAT_EN
        head.sat = op_saturates(bus.in_op);
`endif
    end

    for (genvar k = 0; k < NSTAGE; k++) begin : g_stage
        logic [CHUNK-1:0] s_chunk;
        logic             c_out;
        beat_t            nxt;

        if (k == 0) begin : g_head
            assign sin[k] = head;
        end else begin : g_reg
            beat_t q;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)   q <= '0;
                else if (adv) q <= sout[k-1];
            end
            assign sin[k] = q;
        end

        addsub_slice #(.W(CHUNK)) u_slice (
            .a    (sin[k].a[k*CHUNK +: CHUNK]),
            .b    (sin[k].b[k*CHUNK +: CHUNK]),
            .cin  (sin[k].cy),
            .sum  (s_chunk),
            .cout (c_out)
        );

        always_comb begin
            nxt                     = sin[k];
            nxt.s[k*CHUNK +: CHUNK] = s_chunk;
            nxt.cy                  = c_out;
        end
        assign sout[k] = nxt;
    end

    assign fin = sout[NSTAGE-1];
    assign ovf = (fin.a[WIDTH-1] == fin.b[WIDTH-1]) &&
                 (fin.s[WIDTH-1] != fin.a[WIDTH-1]);

`ifdef ADDSUB_SAT_EN
    always_comb begin
        res = fin.s;
        if (fin.sat && ovf)
            res = fin.a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                 : {1'b0, {(WIDTH-1){1'b1}}};
    end
`else
    assign res = fin.s;
`endif

    always_comb begin
        flags         = '0;
        flags[FLAG_Z] = (res == '0);
        flags[FLAG_N] = res[WIDTH-1];
        flags[FLAG_C] = fin.cy;
        flags[FLAG_V] = ovf;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_flags_q <= '0;
        end else if (adv) begin
            out_valid_q <= fin.vld;
            if (fin.vld) begin
                out_sum_q   <= res;
                out_flags_q <= flags;
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_sum   = out_sum_q;
    assign bus.out_flags = out_flags_q;

endmodule

// File: tb/tb_pipelined_addsub.sv
// Self-checking bench for pipelined_addsub: 8/4, 16/4 and 8/8 configs
// against a signed/unsigned arithmetic reference model.
module tb_pipelined_addsub;
    import addsub_pkg::*;

    logic clk;
    logic rst_n;
    int   n_cmp = 0;
    int   n_bad = 0;
    logic [19:0] q[$];

    addsub_if #(.WIDTH(8))  b8  ();
    addsub_if #(.WIDTH(16)) b16 ();
    addsub_if #(.WIDTH(8))  b88 ();

    pipelined_addsub #(.WIDTH(8), .CHUNK(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .bus(b8)
    );
    pipelined_addsub #(.WIDTH(16), .CHUNK(4)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .bus(b16)
    );
    pipelined_addsub #(.WIDTH(8), .CHUNK(8)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .bus(b88)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Returns {Z,N,C,V, sum[15:0]} from plain integer arithmetic.
    function automatic logic [19:0] ref_model(
        input int w, input logic [15:0] a, input logic [15:0] b,
        input logic [1:0] op, input logic cin
    );
        longint mod, ua, ub, sa, sb, ur, sr, c, rr;
        logic [15:0] r;
        logic z, n, cf, v;
        mod = longint'(1) << w;
        ua  = longint'(a);
        ub  = longint'(b);
        sa  = (ua >= mod / 2) ? ua - mod : ua;
        sb  = (ub >= mod / 2) ? ub - mod : ub;
        c   = (op == OP_ADD) ? 0 : (op == OP_SUB) ? 1 : longint'(cin);
        if (op == OP_SUB || op == OP_SBC) begin
            ur = ua - ub - (1 - c);
            sr = sa - sb - (1 - c);
            cf = (ur >= 0);
        end else begin
            ur = ua + ub + c;
            sr = sa + sb + c;
            cf = (ur >= mod);
        end
        v  = (sr > mod / 2 - 1) || (sr < -(mod / 2));
        rr = ((ur % mod) + mod) % mod;
`ifdef ADDSUB_SAT_EN
        if ((op == OP_ADD || op == OP_SUB) && v)
            rr = (sr > 0) ? mod / 2 - 1 : mod / 2;
`endif
        r = rr[15:0];
        z = (r == 16'h0);
        n = r[w-1];
        return {z, n, cf, v, r};
    endfunction

    // Drives one cycle of random traffic on config d and reports handshakes.
    task automatic step(
        input int d, input bit v, input bit r,
        output bit acc, output bit got, output bit ov, output bit ird,
        output logic [19:0] obs
    );
        logic [31:0] ra, rb, rx;
        logic [15:0] a, b;
        logic [1:0]  op;
        logic        cin;
        int          w;
        @(negedge clk);
        ra  = $urandom;
        rb  = $urandom;
        rx  = $urandom;
        op  = rx[1:0];
        cin = rx[2];
        w   = (d == 1) ? 16 : 8;
        a   = (d == 1) ? ra[15:0] : {8'h00, ra[7:0]};
        b   = (d == 1) ? rb[15:0] : {8'h00, rb[7:0]};
        case (d)
            0: begin
                b8.in_valid = v; b8.in_a = a[7:0]; b8.in_b = b[7:0];
                b8.in_op = op; b8.in_cin = cin; b8.out_ready = r;
            end
            1: begin
                b16.in_valid = v; b16.in_a = a; b16.in_b = b;
                b16.in_op = op; b16.in_cin = cin; b16.out_ready = r;
            end
            default: begin
                b88.in_valid = v; b88.in_a = a[7:0]; b88.in_b = b[7:0];
                b88.in_op = op; b88.in_cin = cin; b88.out_ready = r;
            end
        endcase
        #1;
        case (d)
            0: begin
                acc = b8.in_valid && b8.in_ready;
                got = b8.out_valid && b8.out_ready;
                ov  = b8.out_valid;
                ird = b8.in_ready;
                obs = {b8.out_flags, 8'h00, b8.out_sum};
            end
            1: begin
                acc = b16.in_valid && b16.in_ready;
                got = b16.out_valid && b16.out_ready;
                ov  = b16.out_valid;
                ird = b16.in_ready;
                obs = {b16.out_flags, b16.out_sum};
            end
            default: begin
                acc = b88.in_valid && b88.in_ready;
                got = b88.out_valid && b88.out_ready;
                ov  = b88.out_valid;
                ird = b88.in_ready;
                obs = {b88.out_flags, 8'h00, b88.out_sum};
            end
        endcase
        if (acc) q.push_back(ref_model(w, a, b, op, cin));
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_cmp++;
        if (b8.out_valid !== 1'b0) begin
            n_bad++; $display("FAIL reset_out_valid got %b want 0", b8.out_valid);
        end
        n_cmp++;
        if (b8.out_sum !== 8'h00) begin
            n_bad++; $display("FAIL reset_out_sum got %h want 00", b8.out_sum);
        end
        n_cmp++;
        if (b8.out_flags !== 4'h0) begin
            n_bad++; $display("FAIL reset_out_flags got %b want 0000", b8.out_flags);
        end
        n_cmp++;
        if (b8.in_ready !== 1'b1) begin
            n_bad++; $display("FAIL reset_in_ready got %b want 1", b8.in_ready);
        end
    endtask

    task automatic test_directed();
        logic [7:0] ta [5] = '{8'h7F, 8'h05, 8'h00, 8'hFF, 8'h10};
        logic [7:0] tb [5] = '{8'h01, 8'h05, 8'h01, 8'h00, 8'h01};
        logic [1:0] to [5] = '{OP_ADD, OP_SUB, OP_SUB, OP_ADC, OP_SBC};
        logic       tc [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [7:0] es [5] = '{8'h80, 8'h00, 8'hFF, 8'h00, 8'h0E};
        logic [3:0] ef [5] = '{4'b0101, 4'b1010, 4'b0100, 4'b1010, 4'b0010};
        int lat;
`ifdef ADDSUB_SAT_EN
        es[0] = 8'h7F;
        ef[0] = 4'b0001;
`endif
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            b8.in_valid = 1'b1; b8.in_a = ta[i]; b8.in_b = tb[i];
            b8.in_op = to[i]; b8.in_cin = tc[i]; b8.out_ready = 1'b1;
            @(negedge clk);
            b8.in_valid = 1'b0;
            lat = 1;
            while (!b8.out_valid && lat < 10) begin
                @(negedge clk);
                lat++;
            end
            n_cmp++;
            if (lat != 2) begin
                n_bad++; $display("FAIL directed%0d latency got %0d want 2", i, lat);
            end
            n_cmp++;
            if (b8.out_sum !== es[i]) begin
                n_bad++; $display("FAIL directed%0d sum got %h want %h", i, b8.out_sum, es[i]);
            end
            n_cmp++;
            if (b8.out_flags !== ef[i]) begin
                n_bad++; $display("FAIL directed%0d flags got %b want %b", i, b8.out_flags, ef[i]);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_stream(input int d, input int lat);
        int sent = 0, rcvd = 0, first = -1, last = -1;
        bit acc, got, ov, ird;
        logic [19:0] obs, exp;
        q.delete();
        for (int c = 0; c < 200 && rcvd < 16; c++) begin
            step(d, sent < 16, 1'b1, acc, got, ov, ird, obs);
            if (sent < 16) begin
                n_cmp++;
                if (ird !== 1'b1) begin
                    n_bad++; $display("FAIL stream%0d in_ready got %b want 1", d, ird);
                end
            end
            if (acc) sent++;
            if (got) begin
                n_cmp++;
                if (q.size() == 0) begin
                    n_bad++; $display("FAIL stream%0d spurious beat got %h want none", d, obs);
                end else begin
                    exp = q.pop_front();
                    if (obs !== exp) begin
                        n_bad++; $display("FAIL stream%0d beat%0d got %h want %h", d, rcvd, obs, exp);
                    end
                end
                if (first < 0) first = c;
                last = c;
                rcvd++;
            end
        end
        n_cmp++;
        if (rcvd != 16) begin
            n_bad++; $display("FAIL stream%0d count got %0d want 16", d, rcvd);
        end
        n_cmp++;
        if (first != lat) begin
            n_bad++; $display("FAIL stream%0d latency got %0d want %0d", d, first, lat);
        end
        n_cmp++;
        if (last - first != 15) begin
            n_bad++; $display("FAIL stream%0d span got %0d want 15", d, last - first);
        end
        @(negedge clk);
    endtask

    task automatic test_stall();
        int accn = 0, rcvd = 0;
        bit acc, got, ov, ird, rdy;
        logic [19:0] obs, exp;
        q.delete();
        for (int c = 0; c < 30; c++) begin
            rdy = !(c >= 3 && c <= 7);
            step(0, c < 10, rdy, acc, got, ov, ird, obs);
            if (acc) accn++;
            if (ov && !rdy) begin
                n_cmp++;
                if (ird !== 1'b0) begin
                    n_bad++; $display("FAIL stall_in_ready c%0d got %b want 0", c, ird);
                end
                n_cmp++;
                if (q.size() == 0 || obs !== q[0]) begin
                    n_bad++; $display("FAIL stall_hold c%0d got %h want %h", c, obs,
                                      (q.size() == 0) ? 20'h0 : q[0]);
                end
            end
            if (got) begin
                n_cmp++;
                exp = (q.size() == 0) ? 20'hxxxxx : q.pop_front();
                if (obs !== exp) begin
                    n_bad++; $display("FAIL stall_beat%0d got %h want %h", rcvd, obs, exp);
                end
                rcvd++;
            end
        end
        n_cmp++;
        if (rcvd != accn || q.size() != 0) begin
            n_bad++; $display("FAIL stall_drain got %0d want %0d", rcvd, accn);
        end
    endtask

    task automatic test_reset_midflight();
        bit acc, got, ov, ird;
        logic [19:0] obs;
        q.delete();
        step(0, 1'b1, 1'b1, acc, got, ov, ird, obs);
        step(0, 1'b1, 1'b1, acc, got, ov, ird, obs);
        @(negedge clk);
        b8.in_valid = 1'b0;
        #1;
        n_cmp++;
        if (b8.out_valid !== 1'b1) begin
            n_bad++; $display("FAIL midflight_pre got %b want 1", b8.out_valid);
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (b8.out_valid !== 1'b0) begin
            n_bad++; $display("FAIL midflight_valid got %b want 0", b8.out_valid);
        end
        n_cmp++;
        if ({b8.out_flags, b8.out_sum} !== 12'h000) begin
            n_bad++; $display("FAIL midflight_outs got %h want 000", {b8.out_flags, b8.out_sum});
        end
        @(negedge clk);
        rst_n = 1'b1;
        q.delete();
        for (int c = 0; c < 6; c++) begin
            step(0, 1'b0, 1'b1, acc, got, ov, ird, obs);
            n_cmp++;
            if (ov !== 1'b0) begin
                n_bad++; $display("FAIL midflight_stale c%0d got %b want 0", c, ov);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        b8.in_valid = 1'b0;  b8.in_a = '0;  b8.in_b = '0;
        b8.in_op = OP_ADD;   b8.in_cin = 1'b0;  b8.out_ready = 1'b1;
        b16.in_valid = 1'b0; b16.in_a = '0; b16.in_b = '0;
        b16.in_op = OP_ADD;  b16.in_cin = 1'b0; b16.out_ready = 1'b1;
        b88.in_valid = 1'b0; b88.in_a = '0; b88.in_b = '0;
        b88.in_op = OP_ADD;  b88.in_cin = 1'b0; b88.out_ready = 1'b1;
        test_reset();
        test_directed();
        test_stream(0, 2);
        test_stall();
        test_reset_midflight();
        test_stream(1, 4);
        test_stream(2, 1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
